// File: rtl/cam_array_ctrl_if.sv
// Operation/result bus between the AP controller (master) and one CAM storage array (slave).
interface cam_array_ctrl_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int DATA_DEPTH     = 16,
    parameter int ADDR_WIDTH_CAM = 8
);
    logic                             op_valid;
    logic                             op_ready;
    logic [2:0]                       op_code;
    logic [ADDR_WIDTH_CAM-1:0]        op_addr;
    logic [DATA_WIDTH-1:0]            Ip_row;
    logic [DATA_DEPTH-1:0]            Ip_col;
    logic [DATA_WIDTH-1:0]            Key;
    logic [DATA_WIDTH-1:0]            Mask;
    logic [DATA_WIDTH*DATA_DEPTH-1:0] Q_in;
    logic [DATA_WIDTH*DATA_DEPTH-1:0] Q;
    logic [DATA_DEPTH-1:0]            Q_S;
    logic [DATA_DEPTH-1:0]            tag_row;
    logic                             tag_any;
    logic [ADDR_WIDTH_CAM-1:0]        tag_first;
    logic [DATA_WIDTH-1:0]            rd_row;
    logic [DATA_DEPTH-1:0]            rd_col;
    logic                             done;
    logic                             err;

    modport master (
        output op_valid, op_code, op_addr, Ip_row, Ip_col, Key, Mask, Q_in,
        input  op_ready, Q, Q_S, tag_row, tag_any, tag_first, rd_row, rd_col, done, err
    );

    modport slave (
        input  op_valid, op_code, op_addr, Ip_row, Ip_col, Key, Mask, Q_in,
        output op_ready, Q, Q_S, tag_row, tag_any, tag_first, rd_row, rd_col, done, err
    );
endinterface

// File: rtl/cam_array_ctrl.sv
// Associative-processor storage array: row/column access, bulk load, masked compare into
// registered tags and tag-masked associative write, sequenced as IDLE -> EXEC -> DONE.
module cam_array_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int DATA_DEPTH     = 16,
    parameter int ADDR_WIDTH_CAM = 8
) (
    input  logic             clk,
    input  logic             rstIn,
    cam_array_ctrl_if.slave  bus
);
    localparam int DW = DATA_WIDTH;
    localparam int DD = DATA_DEPTH;
    localparam int AW = ADDR_WIDTH_CAM;
    localparam int RW = (DD > 1) ? $clog2(DD) : 1;
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_WR_ROW    = 3'd1;
    localparam logic [2:0] OP_WR_COL    = 3'd2;
    localparam logic [2:0] OP_RD_ROW    = 3'd3;
    localparam logic [2:0] OP_RD_COL    = 3'd4;
    localparam logic [2:0] OP_LOAD      = 3'd5;
    localparam logic [2:0] OP_COMPARE   = 3'd6;
    localparam logic [2:0] OP_WR_TAGGED = 3'd7;

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_code_q, op_code_d;
    logic [AW-1:0]    op_addr_q, op_addr_d;
    logic [DW-1:0]    ip_row_q, ip_row_d;
    logic [DD-1:0]    ip_col_q, ip_col_d;
    logic [DW-1:0]    key_q, key_d;
    logic [DW-1:0]    mask_q, mask_d;
    logic [DW*DD-1:0] q_in_q, q_in_d;
    logic [DW-1:0]    row_q [DD];
    logic [DW-1:0]    row_d [DD];
    logic [DD-1:0]    tag_row_q, tag_row_d;
    logic             tag_any_q, tag_any_d;
    logic [AW-1:0]    tag_first_q, tag_first_d;
    logic [DW-1:0]    rd_row_q, rd_row_d;
    logic [DD-1:0]    rd_col_q, rd_col_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic          row_ok, col_ok;
    logic [RW-1:0] row_idx;
    logic [CW-1:0] col_idx;

    // Address checks are done at 32 bits so DATA_DEPTH == 2**AW still compares correctly.
    assign row_ok  = 32'(op_addr_q) < 32'(DD);
    assign col_ok  = 32'(op_addr_q) < 32'(DW);
    assign row_idx = op_addr_q[RW-1:0];
    assign col_idx = op_addr_q[CW-1:0];

    always_comb begin
        state_d     = state_q;
        op_code_d   = op_code_q;
        op_addr_d   = op_addr_q;
        ip_row_d    = ip_row_q;
        ip_col_d    = ip_col_q;
        key_d       = key_q;
        mask_d      = mask_q;
        q_in_d      = q_in_q;
        row_d       = row_q;
        tag_row_d   = tag_row_q;
        tag_any_d   = tag_any_q;
        tag_first_d = tag_first_q;
        rd_row_d    = rd_row_q;
        rd_col_d    = rd_col_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    state_d   = ST_EXEC;
                    op_code_d = bus.op_code;
                    op_addr_d = bus.op_addr;
                    ip_row_d  = bus.Ip_row;
                    ip_col_d  = bus.Ip_col;
                    key_d     = bus.Key;
                    mask_d    = bus.Mask;
                    q_in_d    = bus.Q_in;
                end
            end
            ST_EXEC: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                case (op_code_q)
                    OP_WR_ROW: begin
                        if (row_ok) row_d[row_idx] = ip_row_q;
                        else        err_d = 1'b1;
                    end
                    OP_WR_COL: begin
                        if (col_ok) begin
                            for (int i = 0; i < DD; i++) row_d[i][col_idx] = ip_col_q[i];
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    OP_RD_ROW: begin
                        if (row_ok) rd_row_d = row_q[row_idx];
                        else        err_d = 1'b1;
                    end
                    OP_RD_COL: begin
                        if (col_ok) begin
                            for (int i = 0; i < DD; i++) rd_col_d[i] = row_q[i][col_idx];
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    OP_LOAD: begin
                        for (int i = 0; i < DD; i++) row_d[i] = q_in_q[i*DW +: DW];
                    end
                    OP_COMPARE: begin
                        tag_first_d = '0;
                        for (int i = 0; i < DD; i++) tag_row_d[i] = ~|((row_q[i] ^ key_q) & mask_q);
                        // Descending scan so the lowest tagged index is the one left standing.
                        for (int i = DD - 1; i >= 0; i--) begin
                            if (tag_row_d[i]) tag_first_d = AW'(i);
                        end
                        tag_any_d = |tag_row_d;
                    end
                    OP_WR_TAGGED: begin
                        for (int i = 0; i < DD; i++) begin
                            if (tag_row_q[i]) row_d[i] = (row_q[i] & ~mask_q) | (key_q & mask_q);
                        end
                    end
                    default: ;
                endcase
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstIn) begin
        if (rstIn) begin
            state_q     <= ST_IDLE;
            op_code_q   <= '0;
            op_addr_q   <= '0;
            ip_row_q    <= '0;
            ip_col_q    <= '0;
            key_q       <= '0;
            mask_q      <= '0;
            q_in_q      <= '0;
            for (int i = 0; i < DD; i++) row_q[i] <= '0;
            tag_row_q   <= '0;
            tag_any_q   <= 1'b0;
            tag_first_q <= '0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_code_q   <= op_code_d;
            op_addr_q   <= op_addr_d;
            ip_row_q    <= ip_row_d;
            ip_col_q    <= ip_col_d;
            key_q       <= key_d;
            mask_q      <= mask_d;
            q_in_q      <= q_in_d;
            row_q       <= row_d;
            tag_row_q   <= tag_row_d;
            tag_any_q   <= tag_any_d;
            tag_first_q <= tag_first_d;
            rd_row_q    <= rd_row_d;
            rd_col_q    <= rd_col_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        bus.Q   = '0;
        bus.Q_S = '0;
        for (int i = 0; i < DD; i++) begin
            bus.Q[i*DW +: DW] = row_q[i];
            bus.Q_S[i]        = row_q[i][DW-1];
        end
    end

    assign bus.op_ready  = (state_q == ST_IDLE) && !rstIn;
    assign bus.tag_row   = tag_row_q;
    assign bus.tag_any   = tag_any_q;
    assign bus.tag_first = tag_first_q;
    assign bus.rd_row    = rd_row_q;
    assign bus.rd_col    = rd_col_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule
